// File: rtl/add_sub_serial_if.sv
// Handshake/operand bundle for the bit-serial adder/subtractor.
// The controller side uses the master modport, the arithmetic unit uses slave.
// Optional signed-overflow flag appears only when ADD_SUB_OVF_EN is defined.
interface add_sub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             select;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ans;
  logic             cout;
`ifdef ADD_SUB_OVF_EN
  logic             ovf;

  modport master (output start, select, x, y, input busy, done, ans, cout, ovf);
  modport slave  (input start, select, x, y, output busy, done, ans, cout, ovf);
`else
  modport master (output start, select, x, y, input busy, done, ans, cout);
  modport slave  (input start, select, x, y, output busy, done, ans, cout);
`endif
endinterface

// File: rtl/add_sub_serial.sv
// Bit-serial LSB-first adder/subtractor: one operand pair per start pulse,
// one result bit per clock, done pulses WIDTH cycles after the accept edge.
// Subtraction is x + ~y + 1, the +1 entering as the initial carry.
// Optional feature macro: ADD_SUB_OVF_EN (signed overflow flag on ovf).
module add_sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  add_sub_serial_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   x_reg;
  logic [WIDTH-1:0]   y_reg;
  logic               sel_reg;
  logic [WIDTH-2:0]   res_sr;
  logic [WIDTH-1:0]   ans_reg;
  logic               cout_reg;
  logic               done_reg;
  logic               busy;
  logic               accept;
  logic               last_bit;
  logic               b_bit;
  logic               sum_bit;
  logic               carry_nxt;
  logic [WIDTH-1:0]   res_nxt;

  // State register.
  // NOTE: clocked state always uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: a run lasts exactly WIDTH bit-steps.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = RUN;
      RUN:  if (last_bit)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: start is only honoured in IDLE, the last bit ends the run.
  always_comb begin
    busy     = (state == RUN);
    accept   = (state == IDLE) && bus.start;
    last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  end

  // One full-adder slice; y is inverted for subtraction.
  always_comb begin
    b_bit     = y_reg[cnt] ^ sel_reg;
    sum_bit   = x_reg[cnt] ^ b_bit ^ carry;
    carry_nxt = (x_reg[cnt] & b_bit) | (x_reg[cnt] & carry) | (b_bit & carry);
    res_nxt   = {sum_bit, res_sr};
  end

  // Operand capture at accept; later input changes are ignored until the next accept.
  // NOTE: these operand holding registers carry no reset; they are always
  // written at accept before being read, so reset would only cost routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_reg   <= bus.x;
      y_reg   <= bus.y;
      sel_reg <= bus.select;
    end
  end

  // Bit counter, running carry and partial-result shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      res_sr <= '0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= bus.select;
    end else if (busy) begin
      cnt    <= cnt + 1'b1;
      carry  <= carry_nxt;
      res_sr <= res_nxt[WIDTH-1:1];
    end
  end

  // Visible results: updated only on the last bit so partial sums never leak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ans_reg  <= '0;
      cout_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= last_bit;
      if (last_bit) begin
        ans_reg  <= res_nxt;
        cout_reg <= carry_nxt;
      end
    end
  end

`ifdef ADD_SUB_OVF_EN
  logic ovf_reg;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_reg <= 1'b0;
    else if (last_bit) ovf_reg <= carry ^ carry_nxt;
  end

  assign bus.ovf = ovf_reg;
`endif

  assign bus.busy = busy;
  assign bus.done = done_reg;
  assign bus.ans  = ans_reg;
  assign bus.cout = cout_reg;

endmodule
